// File: rtl/dff.sv
// Enable-gated register with synchronous active-high reset to RST_V.
module dff #(
    parameter int              SIZE  = 1,
    parameter logic [SIZE-1:0] RST_V = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)     r_q <= RST_V;
        else if (en) r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: valid flag plus data register, with flush and
// optional zeroisation so an empty stage never keeps a stale share value.
module dff_pipe_stage #(
    parameter int              SIZE  = 1,
    parameter logic [SIZE-1:0] RST_V = '0,
    parameter int              ZERO  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    input  logic            v_in,
    input  logic [SIZE-1:0] d_in,
    output logic            v_q,
    output logic [SIZE-1:0] d_q
);

    logic            r_v;
    logic            w_en;
    logic [SIZE-1:0] w_d;

    always_ff @(posedge clk) begin
        if (rst || clr) r_v <= 1'b0;
        else if (adv)   r_v <= v_in;
    end

    // Without zeroisation a flush leaves the data register untouched.
    assign w_en = clr ? (ZERO != 0) : adv;
    assign w_d  = ((ZERO != 0) && (clr || !v_in)) ? RST_V : d_in;

    dff #(.SIZE(SIZE), .RST_V(RST_V)) u_dff (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .d   (w_d),
        .q   (d_q)
    );

    assign v_q = r_v;

endmodule

// File: rtl/dff_pipe.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshake,
// bubble collapsing, synchronous flush and occupancy count.
module dff_pipe #(
    parameter int              SIZE  = 1,
    parameter int              DEPTH = 2,
    parameter logic [SIZE-1:0] RST_V = '0,
    parameter int              ZERO  = 1,
    localparam int             CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SIZE-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0]           w_v;
    logic [DEPTH-1:0]           w_adv;
    logic [DEPTH-1:0]           w_vin;
    logic [DEPTH-1:0][SIZE-1:0] w_din;
    logic [DEPTH-1:0][SIZE-1:0] w_d;
    logic                       w_accept;
    logic                       w_consume;
    logic [CNT_W-1:0]           r_count;

    // A stage may advance if any stage from it to the output is empty or the
    // consumer takes the last word; this is what collapses bubbles.
    always_comb begin
        logic a;
        a     = out_ready;
        w_adv = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            a        = a | ~w_v[k];
            w_adv[k] = a;
        end
    end

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_vin[k] = in_valid;
                assign w_din[k] = in_data;
            end else begin : g_body
                assign w_vin[k] = w_v[k-1];
                assign w_din[k] = w_d[k-1];
            end

            dff_pipe_stage #(.SIZE(SIZE), .RST_V(RST_V), .ZERO(ZERO)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .clr  (flush),
                .adv  (w_adv[k]),
                .v_in (w_vin[k]),
                .d_in (w_din[k]),
                .v_q  (w_v[k]),
                .d_q  (w_d[k])
            );
        end
    endgenerate

    assign in_ready  = w_adv[0] & ~flush & ~rst;
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) r_count <= '0;
        else              r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_consume);
    end

    assign count = r_count;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed and randomised checks of dff_pipe: handshake, latency, back-pressure,
// bubble collapse, flush/zeroise, reset, and a scoreboard over random traffic.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, out_ready, flush;
    logic       a_in_ready, a_out_valid, z_in_ready, z_out_valid;
    logic [7:0] a_out_data, z_out_data;
    logic [1:0] a_count, z_count;

    logic        rin_valid[2], rin_ready[2], rout_valid[2], rout_ready[2], rflush[2];
    logic [15:0] rin_data[2], rout_data[2];
    logic [0:0]  r1_count;
    logic [2:0]  r4_count;
    logic        hold[2];
    logic [15:0] seq[2];
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dff_pipe #(.SIZE(8), .DEPTH(3), .RST_V(8'h00), .ZERO(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .flush(flush), .count(a_count));

    dff_pipe #(.SIZE(8), .DEPTH(3), .RST_V(8'h00), .ZERO(0)) dut_z (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(z_in_ready),
        .out_data(z_out_data), .out_valid(z_out_valid), .out_ready(out_ready),
        .flush(flush), .count(z_count));

    dff_pipe #(.SIZE(16), .DEPTH(1), .RST_V(16'h0000), .ZERO(1)) dut_r1 (
        .clk(clk), .rst(rst), .in_data(rin_data[0]), .in_valid(rin_valid[0]), .in_ready(rin_ready[0]),
        .out_data(rout_data[0]), .out_valid(rout_valid[0]), .out_ready(rout_ready[0]),
        .flush(rflush[0]), .count(r1_count));

    dff_pipe #(.SIZE(16), .DEPTH(4), .RST_V(16'h0000), .ZERO(1)) dut_r4 (
        .clk(clk), .rst(rst), .in_data(rin_data[1]), .in_valid(rin_valid[1]), .in_ready(rin_ready[1]),
        .out_data(rout_data[1]), .out_valid(rout_valid[1]), .out_ready(rout_ready[1]),
        .flush(rflush[1]), .count(r4_count));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard step for one random DUT; called after inputs settle, before the edge.
    task automatic rnd_chk(input int d);
        int          dep, qs, cnt, pc;
        logic [15:0] exp;
        string       n;
        n   = (d == 0) ? "r1" : "r4";
        dep = (d == 0) ? 1 : 4;
        qs  = (d == 0) ? q0.size() : q1.size();
        cnt = (d == 0) ? int'(r1_count) : int'(r4_count);
        pc  = (d == 0) ? int'(dut_r1.g_stage[0].u_stage.v_q)
                       : int'(dut_r4.g_stage[0].u_stage.v_q) + int'(dut_r4.g_stage[1].u_stage.v_q)
                       + int'(dut_r4.g_stage[2].u_stage.v_q) + int'(dut_r4.g_stage[3].u_stage.v_q);
        chk({n, "_count_sb"}, 32'(cnt), 32'(qs));
        chk({n, "_count_pop"}, 32'(cnt), 32'(pc));
        chk({n, "_in_ready"}, 32'(rin_ready[d]), 32'((qs < dep || rout_ready[d]) && !rflush[d]));
        if (rout_valid[d]) begin
            chk({n, "_ovalid_nonempty"}, 32'(qs > 0), 32'd1);
            if (rout_ready[d] && qs > 0) begin
                exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk({n, "_out_data"}, 32'(rout_data[d]), 32'(exp));
            end
        end
        if (rin_valid[d] && rin_ready[d]) begin
            if (d == 0) q0.push_back(rin_data[d]);
            else        q1.push_back(rin_data[d]);
            seq[d]  = seq[d] + 16'd1;
            hold[d] = 1'b0;
        end else begin
            hold[d] = rin_valid[d];
        end
        if (rflush[d]) begin
            if (d == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    initial begin
        int exp_cnt, acc, con;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0; flush = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rin_valid[d] = 1'b0; rin_data[d] = '0; rout_ready[d] = 1'b0;
            rflush[d] = 1'b0; hold[d] = 1'b0; seq[d] = 16'h0;
        end

        // reset held 2 cycles with in_valid high
        tick(); tick();
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'h00);
        chk("rst_out_data_z", 32'(z_out_data), 32'h00);
        rst = 1'b0; in_valid = 1'b0;
        tick();

        // streaming 01..0A, out_ready high: 3-cycle latency, count holds 3
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_data  = 8'(c + 1);
            #1;
            acc = (c < 10) ? c : 10;
            con = (c < 3) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
            exp_cnt = acc - con;
            chk("str_in_ready", 32'(a_in_ready), 32'd1);
            chk("str_out_valid", 32'(a_out_valid), 32'(c >= 3 && c < 13));
            chk("str_count", 32'(a_count), 32'(exp_cnt));
            if (c >= 3 && c < 13) chk("str_out_data", 32'(a_out_data), 32'(c - 2));
            tick();
        end

        // back-pressure: three fill, fourth waits until the first leaves
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h11 + i);
            #1;
            chk("bp_in_ready", 32'(a_in_ready), 32'd1);
            tick();
        end
        in_data = 8'h14;
        #1;
        chk("bp_full_in_ready", 32'(a_in_ready), 32'd0);
        chk("bp_full_count", 32'(a_count), 32'd3);
        chk("bp_full_out_data", 32'(a_out_data), 32'h11);
        tick();
        chk("bp_frozen_count", 32'(a_count), 32'd3);
        chk("bp_frozen_out_data", 32'(a_out_data), 32'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(a_in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(a_out_valid), 32'd1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        chk("bp_after_count", 32'(a_count), 32'd3);
        chk("bp_after_out_data", 32'(a_out_data), 32'h12);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_drain_data", 32'(a_out_data), 32'(8'h12 + i));
            tick();
        end
        chk("empty_count", 32'(a_count), 32'd0);
        chk("empty_out_valid", 32'(a_out_valid), 32'd0);
        chk("empty_out_data", 32'(a_out_data), 32'h00);

        // bubble collapse: lone word runs to the last stage, gapped words pack in
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h21;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("bub_out_valid", 32'(a_out_valid), 32'd1);
        chk("bub_out_data", 32'(a_out_data), 32'h21);
        chk("bub_count1", 32'(a_count), 32'd1);
        in_valid = 1'b1; in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h23;
        #1;
        chk("bub_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bub_count3", 32'(a_count), 32'd3);
        chk("bub_full_in_ready", 32'(a_in_ready), 32'd0);
        chk("bub_no_hole", 32'({dut_a.g_stage[2].u_stage.v_q, dut_a.g_stage[1].u_stage.v_q,
                                dut_a.g_stage[0].u_stage.v_q}), 32'h7);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bub_drain_data", 32'(a_out_data), 32'(8'h21 + i));
            tick();
        end

        // flush with two words held; ZERO=1 wipes data, ZERO=0 keeps it
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        tick();
        chk("fl_pre_out_data", 32'(a_out_data), 32'h31);
        chk("fl_pre_count", 32'(a_count), 32'd2);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        #1;
        chk("fl_in_ready", 32'(a_in_ready), 32'd0);
        chk("fl_in_ready_z", 32'(z_in_ready), 32'd0);
        chk("fl_out_valid_live", 32'(a_out_valid), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_count", 32'(a_count), 32'd0);
        chk("fl_out_valid", 32'(a_out_valid), 32'd0);
        chk("fl_out_data_zero", 32'(a_out_data), 32'h00);
        chk("fl_stage1_zero", 32'(dut_a.g_stage[1].u_stage.d_q), 32'h00);
        chk("fl_count_z", 32'(z_count), 32'd0);
        chk("fl_out_valid_z", 32'(z_out_valid), 32'd0);
        chk("fl_out_data_kept_z", 32'(z_out_data), 32'h31);
        chk("fl_stage1_kept_z", 32'(dut_z.g_stage[1].u_stage.d_q), 32'h32);
        in_valid = 1'b1; in_data = 8'h34;
        #1;
        chk("fl_next_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        chk("fl_next_count", 32'(a_count), 32'd1);

        // reset in mid-transfer drops everything
        in_data = 8'h41;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_mid_count", 32'(a_count), 32'd0);
        chk("rst_mid_out_valid", 32'(a_out_valid), 32'd0);
        tick();

        // random traffic on DEPTH=1 and DEPTH=4 against a scoreboard
        for (int c = 0; c < 10000; c++) begin
            for (int d = 0; d < 2; d++) begin
                rflush[d]     = ($urandom_range(0, 39) == 0);
                rout_ready[d] = ($urandom_range(0, 3) != 0);
                if (!hold[d]) begin
                    rin_valid[d] = ($urandom_range(0, 3) != 0);
                    rin_data[d]  = seq[d];
                end
            end
            #1;
            rnd_chk(0);
            rnd_chk(1);
            tick();
        end
        chk("rnd_r1_progress", 32'(seq[0] > 16'd1000), 32'd1);
        chk("rnd_r4_progress", 32'(seq[1] > 16'd1000), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
